// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder controller: state encoding,
// default operand width and the bit-counter width helper.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // A one-bit operand still needs a one-bit counter.
    function automatic int cnt_width(input int w);
        return (w <= 1) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/fa_bit.sv
// Single-bit full adder cell, purely combinational; the serial controller
// time-multiplexes this one cell over every operand bit.
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ cin;
    assign carry = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: feeds one fa_bit cell LSB first, one bit per clock.
// Optional subtract mode (A-B, two's complement) under SERIAL_ADDER_SUB_EN.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output state_t           state_dbg
);

    // Handshake: start is sampled only in IDLE; the accepting edge raises busy,
    // and done is a single-cycle pulse in the cycle after the last bit edge.

    localparam int CW = cnt_width(WIDTH);

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_sh, b_sh, res_sh, res_next;
    logic [WIDTH-1:0] b_load;
    logic             c_load;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             last;
    logic             fa_s, fa_c;

    fa_bit u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .sum  (fa_s),
        .carry(fa_c)
    );

`ifdef SERIAL_ADDER_SUB_EN
    // Subtract as A + ~B + 1, so cout=1 means no borrow.
    assign b_load = sub ? ~b : b;
    assign c_load = sub ? 1'b1 : cin;
`else
    assign b_load = b;
    assign c_load = cin;
`endif

    assign last = (cnt == CW'(WIDTH - 1));

    always_comb begin
        res_next            = res_sh >> 1;
        res_next[WIDTH-1]   = fa_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: if (start) state_nx = RUN;
            RUN: begin
                busy = 1'b1;
                if (last) state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    a_sh   <= a;
                    b_sh   <= b_load;
                    carry  <= c_load;
                    res_sh <= '0;
                    cnt    <= '0;
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    carry  <= fa_c;
                    res_sh <= res_next;
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        sum  <= res_next;
                        cout <= fa_c;
                    end
                end
                default: ;
            endcase
        end
    end

    assign state_dbg = state;

endmodule
